dma_mode_switch_ctrl: RTL and testbench
=======================================

# dma_mode_switch_ctrl

Sequences direction changes of the DMA AXI-MM source/destination mux. Owns the registered `mode` select driving the mux, and tracks outstanding read and write traffic on the DMA side of the mux. A requested mode change is applied only after all in-flight bursts have drained, so no transaction is ever split across two memory targets. Sits between the DMA CSR/descriptor logic, which requests modes, and the mux plus DMA engine.

## Interface
- `MAX_OUTSTANDING`, 64: max in-flight bursts per counter; counter width is `$clog2(MAX_OUTSTANDING+1)`.
- `clk` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: mode-change request; held until `req_ready`.
- `req_mode` in `dma_pkg::e_dma_mode`: requested mode; stable while `req_valid`.
- `req_ready` out 1: one-cycle acknowledge; the new mode is already in effect.
- `mode` out `dma_pkg::e_dma_mode`: select to the mux.
- `hold_off` out 1: engine must not raise new `arvalid`/`awvalid`.
- `src_ar_hs`, `src_r_last_hs` in 1: `src_mem` AR handshake; R handshake with `rlast`.
- `dest_aw_hs`, `dest_w_last_hs`, `dest_b_hs` in 1: `dest_mem` AW handshake, W handshake with `wlast`, B handshake.
- `busy` out 1: any counter is non-zero.
- `err_ovf`, `err_udf` out 1: sticky counter overflow/underflow flags; cleared only by reset.

## Operation
- Three counters:
  - `rd_cnt`: +1 on `src_ar_hs`, −1 on `src_r_last_hs`.
  - `aw_cnt`: +1 on `dest_aw_hs`, −1 on `dest_b_hs`.
  - `wd_cnt`: +1 on `dest_w_last_hs`, −1 on `dest_b_hs`.
- Counter update rules:
  - Increment and decrement in the same cycle: no change.
  - Increment at `MAX_OUTSTANDING`: hold the value, set `err_ovf`.
  - Decrement at 0: hold 0, set `err_udf`.
- Counters run in every FSM state. Handshakes in progress when `hold_off` rises are counted and drained.
- Drain condition `idle`: all three registered counters are 0 and no handshake input is high this cycle.
- FSM states and transitions:
  - RUN → ACK when `req_valid` and `req_mode == mode`.
  - RUN → DRAIN when `req_valid` and `req_mode != mode`.
  - DRAIN → SWITCH when `idle`. `mode <= req_mode` is registered on this transition.
  - SWITCH → ACK unconditionally. This gives one settle cycle with the new select before traffic resumes.
  - ACK → RUN unconditionally. `req_ready = 1` in ACK only.
- `hold_off = 1` in DRAIN, SWITCH and ACK; 0 in RUN.
- Drain has no timeout. It waits indefinitely; `busy` and the counters are visible for debug.
- Reset values: state RUN, `mode = dma_pkg::DMA_MODE_RESET` (DDR_TO_HOST), all counters 0, `req_ready = 0`, `hold_off = 0`, `busy = 0`, `err_ovf = 0`, `err_udf = 0`.
- Reset asserted mid-drain or mid-switch: immediate return to reset values. A pending request is dropped; the requester must re-present it.
- An illegal `req_mode` encoding is applied as-is. The mux's default arm handles it.

## Timing
- All outputs are registered or Moore-decoded from registered state. There is no combinational path from inputs to outputs.
- Same-mode request sampled at cycle 0: `req_ready = 1` at cycle 1, RUN at cycle 2.
- Different mode, `idle` at cycle 1:
  - cycle 1: DRAIN, `hold_off = 1`.
  - cycle 2: SWITCH, new `mode`.
  - cycle 3: ACK.
  - cycle 4: RUN, `hold_off = 0`.
- Different mode, not idle: DRAIN lasts until the first cycle `idle` is true, plus fixed 3-cycle tail (SWITCH, ACK, RUN).
- `req_valid` is sampled only in RUN. A request still high in ACK is not re-accepted in the same cycle.
- `busy` lags counter-affecting handshakes by one cycle.

## Structure
- `dma_pkg` gains the constant `DMA_MODE_RESET = DDR_TO_HOST`.
- FSM state enum is local to the module.
- Sub-module `dma_outstanding_cnt` provides one saturating up/down counter with `inc`, `dec`, `cnt`, `zero`, `ovf` and `udf`. It is instantiated three times.

## Test plan
- Release from reset, no stimulus → `mode` = DDR_TO_HOST, `hold_off` = 0, `req_ready` = 0, `busy` = 0 for 10 cycles.
- `req_mode` = DDR_TO_HOST with counters idle → `req_ready` one cycle after `req_valid`, `mode` unchanged, `hold_off` high for exactly 1 cycle.
- `req_mode` = HOST_TO_DDR with idle counters → `mode` changes 2 cycles after request, `req_ready` at +3, `hold_off` deasserts at +4.
- 3 AR handshakes, then switch request, then 3 `rlast` spaced 5 cycles apart → `mode` unchanged until the cycle after the third `rlast`, then standard 3-cycle tail.
- AW+W, switch request, B returned in the same cycle as a new AW → `aw_cnt` stays 1, drain waits for the second B.
- `dest_b_hs` with all counters 0 → `err_udf` = 1, sticky. Assert `reset` during DRAIN → `mode` = DDR_TO_HOST, `hold_off` = 0, `err_udf` = 0 immediately.

Source files
------------

// File: rtl/dma_pkg.sv
// dma_pkg: shared DMA types.
//   e_dma_mode     : select encoding for the AXI-MM source/destination mux.
//                    The 2-bit field leaves one code unused; the mux's
//                    default arm deals with it.
//   DMA_MODE_RESET : mux select that is in effect when reset is released.
package dma_pkg;

  typedef enum logic [1:0] {
    DDR_TO_HOST  = 2'd0,
    HOST_TO_DDR  = 2'd1,
    HOST_TO_HOST = 2'd2
  } e_dma_mode;

  localparam e_dma_mode DMA_MODE_RESET = DDR_TO_HOST;

  // Width of a counter that must be able to hold 0..max_out.
  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/dma_outstanding_cnt.sv
// dma_outstanding_cnt: saturating up/down counter of in-flight bursts.
//   clk, reset : clock, asynchronous active-high reset
//   inc, dec   : +1 / -1 requests; both high in one cycle cancel out
//   cnt        : registered count, 0..MAX_OUTSTANDING
//   zero       : cnt == 0
//   ovf, udf   : single-cycle pulses when an increment at the ceiling or a
//                decrement at zero is refused (count is held)
module dma_outstanding_cnt
  import dma_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 64,
  parameter int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             ovf,
  output logic             udf
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] cnt_reg;
  logic             up;
  logic             down;

  assign up   = inc && !dec;
  assign down = dec && !inc;

  assign ovf  = up && (cnt_reg == CNT_MAX);
  assign udf  = down && (cnt_reg == '0);
  assign zero = (cnt_reg == '0);
  assign cnt  = cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (up && !ovf) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end else if (down && !udf) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

endmodule

// File: rtl/dma_mode_switch_ctrl.sv
// dma_mode_switch_ctrl: sequences direction changes of the DMA AXI-MM mux.
// A new mode is only applied once every in-flight read and write burst on
// the DMA side has drained, so no transaction straddles two targets.
//   clk, reset                   : clock, asynchronous active-high reset
//   req_valid, req_mode          : mode-change request (held until ready)
//   req_ready                    : one-cycle ack, new mode already active
//   mode                         : registered mux select
//   hold_off                     : engine must not start new AR/AW
//   src_ar_hs, src_r_last_hs     : read address / last read data handshakes
//   dest_aw_hs, dest_w_last_hs,
//   dest_b_hs                    : write address / last write data / response
//   busy                         : any outstanding counter non-zero
//   err_ovf, err_udf             : sticky counter overflow / underflow
module dma_mode_switch_ctrl
  import dma_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      req_valid,
  input  e_dma_mode req_mode,
  output logic      req_ready,
  output e_dma_mode mode,
  output logic      hold_off,
  input  logic      src_ar_hs,
  input  logic      src_r_last_hs,
  input  logic      dest_aw_hs,
  input  logic      dest_w_last_hs,
  input  logic      dest_b_hs,
  output logic      busy,
  output logic      err_ovf,
  output logic      err_udf
);

  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);
  localparam int N_CNT = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_ACK    = 2'd3
  } e_state;

  e_state    state_reg, state_next;
  e_dma_mode mode_reg, mode_next;
  logic      err_ovf_reg, err_udf_reg;

  // Counter order: 0 = rd_cnt, 1 = aw_cnt, 2 = wd_cnt.
  // A B response retires both the address and the data side of a write.
  logic [N_CNT-1:0] inc_vec, dec_vec, zero_vec, ovf_vec, udf_vec, nz_vec;
  logic [CNT_W-1:0] cnt_arr [N_CNT];

  assign inc_vec = {dest_w_last_hs, dest_aw_hs, src_ar_hs};
  assign dec_vec = {dest_b_hs,      dest_b_hs,  src_r_last_hs};

  generate
    for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
      dma_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
      ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_vec[gi]),
        .dec   (dec_vec[gi]),
        .cnt   (cnt_arr[gi]),
        .zero  (zero_vec[gi]),
        .ovf   (ovf_vec[gi]),
        .udf   (udf_vec[gi])
      );
      assign nz_vec[gi] = (cnt_arr[gi] != '0);
    end
  endgenerate

  // A handshake this cycle means the counters are about to move, so the
  // drain is not complete even if every registered count reads zero.
  logic idle;
  assign idle = (&zero_vec) && !(|inc_vec) && !(|dec_vec);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_RUN;
      mode_reg    <= DMA_MODE_RESET;
      err_ovf_reg <= 1'b0;
      err_udf_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mode_reg    <= mode_next;
      err_ovf_reg <= err_ovf_reg | (|ovf_vec);
      err_udf_reg <= err_udf_reg | (|udf_vec);
    end
  end

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    req_ready  = 1'b0;
    hold_off   = 1'b1;
    case (state_reg)
      ST_RUN: begin
        hold_off = 1'b0;
        if (req_valid) begin
          state_next = (req_mode == mode_reg) ? ST_ACK : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (idle) begin
          state_next = ST_SWITCH;
          mode_next  = req_mode;
        end
      end
      // One settle cycle with the new select before the ack releases traffic.
      ST_SWITCH: state_next = ST_ACK;
      ST_ACK: begin
        req_ready  = 1'b1;
        state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  assign mode    = mode_reg;
  assign busy    = |nz_vec;
  assign err_ovf = err_ovf_reg;
  assign err_udf = err_udf_reg;

endmodule

// File: tb/tb_dma_mode_switch_ctrl.sv
module tb_dma_mode_switch_ctrl;
  import dma_pkg::*;

  logic      clk = 1'b0;
  logic      reset = 1'b1;
  logic      req_valid = 1'b0;
  e_dma_mode req_mode = DDR_TO_HOST;
  logic      req_ready;
  e_dma_mode mode;
  logic      hold_off;
  logic      src_ar_hs = 1'b0, src_r_last_hs = 1'b0;
  logic      dest_aw_hs = 1'b0, dest_w_last_hs = 1'b0, dest_b_hs = 1'b0;
  logic      busy, err_ovf, err_udf;

  dma_mode_switch_ctrl #(.MAX_OUTSTANDING(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_mode       (req_mode),
    .req_ready      (req_ready),
    .mode           (mode),
    .hold_off       (hold_off),
    .src_ar_hs      (src_ar_hs),
    .src_r_last_hs  (src_r_last_hs),
    .dest_aw_hs     (dest_aw_hs),
    .dest_w_last_hs (dest_w_last_hs),
    .dest_b_hs      (dest_b_hs),
    .busy           (busy),
    .err_ovf        (err_ovf),
    .err_udf        (err_udf)
  );

  always #5 clk = ~clk;

  // Index of the most recent rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each accepted request pushes the mode it must end up in and
  // the edge after which its req_ready pulse must be visible.
  typedef struct {
    e_dma_mode m;
    int        ack_cyc;
  } sb_item_t;

  sb_item_t sb[$];
  sb_item_t sb_item;

  always @(negedge clk) begin
    if (!reset && req_ready) begin
      if (sb.size() == 0) begin
        chk("ack_unexpected", 32'd1, 32'd0);
      end else begin
        sb_item = sb.pop_front();
        $display("ack mode=%0d cyc=%0d exp_mode=%0d exp_cyc=%0d",
                 mode, cyc, sb_item.m, sb_item.ack_cyc);
        chk("ack_mode", 32'(mode), 32'(sb_item.m));
        chk("ack_cyc", 32'(cyc), 32'(sb_item.ack_cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int e0;

  initial begin
    repeat (3) tick();
    reset = 1'b0;

    // Quiet after reset.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_mode", 32'(mode), 32'(DDR_TO_HOST));
      chk("rst_hold", 32'(hold_off), 32'd0);
      chk("rst_rdy", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    chk("rst_ovf", 32'(err_ovf), 32'd0);
    chk("rst_udf", 32'(err_udf), 32'd0);

    // Same-mode request: ack one cycle later, one cycle of hold_off.
    req_valid = 1'b1; req_mode = DDR_TO_HOST; e0 = cyc + 1;
    sb.push_back('{DDR_TO_HOST, e0});
    tick();
    chk("same_hold", 32'(hold_off), 32'd1);
    chk("same_rdy", 32'(req_ready), 32'd1);
    chk("same_mode", 32'(mode), 32'(DDR_TO_HOST));
    req_valid = 1'b0;
    tick();
    chk("same_hold_end", 32'(hold_off), 32'd0);
    chk("same_rdy_end", 32'(req_ready), 32'd0);
    tick();

    // Different mode with idle counters: DRAIN, SWITCH, ACK, RUN.
    req_valid = 1'b1; req_mode = HOST_TO_DDR; e0 = cyc + 1;
    sb.push_back('{HOST_TO_DDR, e0 + 2});
    tick();
    chk("sw_hold", 32'(hold_off), 32'd1);
    chk("sw_mode_old", 32'(mode), 32'(DDR_TO_HOST));
    chk("sw_rdy_early", 32'(req_ready), 32'd0);
    tick();
    chk("sw_mode_new", 32'(mode), 32'(HOST_TO_DDR));
    chk("sw_rdy_early2", 32'(req_ready), 32'd0);
    tick();
    chk("sw_rdy", 32'(req_ready), 32'd1);
    chk("sw_hold_ack", 32'(hold_off), 32'd1);
    req_valid = 1'b0;
    tick();
    chk("sw_hold_end", 32'(hold_off), 32'd0);
    chk("sw_rdy_end", 32'(req_ready), 32'd0);

    // Three reads outstanding, switch back, rlast every 5 cycles.
    src_ar_hs = 1'b1;
    repeat (3) tick();
    src_ar_hs = 1'b0;
    chk("rd_busy", 32'(busy), 32'd1);
    req_valid = 1'b1; req_mode = DDR_TO_HOST; e0 = cyc + 1;
    sb.push_back('{DDR_TO_HOST, e0 + 14});
    tick();
    chk("rd_hold", 32'(hold_off), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      src_r_last_hs = (k == 2 || k == 7 || k == 12);
      tick();
      chk("rd_mode_held", 32'(mode), 32'(HOST_TO_DDR));
      if (k == 7) chk("rd_busy_mid", 32'(busy), 32'd1);
    end
    src_r_last_hs = 1'b0;
    chk("rd_busy_done", 32'(busy), 32'd0);
    tick();
    chk("rd_mode_new", 32'(mode), 32'(DDR_TO_HOST));
    chk("rd_rdy_early", 32'(req_ready), 32'd0);
    tick();
    chk("rd_rdy", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    tick();
    chk("rd_hold_end", 32'(hold_off), 32'd0);

    // One write outstanding; B arrives with a new AW+W, drain waits for 2nd B.
    dest_aw_hs = 1'b1; dest_w_last_hs = 1'b1;
    tick();
    dest_aw_hs = 1'b0; dest_w_last_hs = 1'b0;
    req_valid = 1'b1; req_mode = HOST_TO_DDR; e0 = cyc + 1;
    sb.push_back('{HOST_TO_DDR, e0 + 7});
    tick();
    chk("wr_hold", 32'(hold_off), 32'd1);
    tick();
    dest_b_hs = 1'b1; dest_aw_hs = 1'b1; dest_w_last_hs = 1'b1;
    tick();
    dest_b_hs = 1'b0; dest_aw_hs = 1'b0; dest_w_last_hs = 1'b0;
    chk("wr_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("wr_mode_held", 32'(mode), 32'(DDR_TO_HOST));
    end
    dest_b_hs = 1'b1;
    tick();
    dest_b_hs = 1'b0;
    chk("wr_mode_held2", 32'(mode), 32'(DDR_TO_HOST));
    chk("wr_busy_done", 32'(busy), 32'd0);
    tick();
    chk("wr_mode_new", 32'(mode), 32'(HOST_TO_DDR));
    tick();
    chk("wr_rdy", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    tick();
    chk("wr_hold_end", 32'(hold_off), 32'd0);
    chk("wr_no_udf", 32'(err_udf), 32'd0);

    // Underflow is sticky.
    dest_b_hs = 1'b1;
    tick();
    dest_b_hs = 1'b0;
    chk("udf_set", 32'(err_udf), 32'd1);
    chk("udf_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("udf_sticky", 32'(err_udf), 32'd1);
    end
    chk("udf_no_ovf", 32'(err_ovf), 32'd0);

    // Reset in the middle of a drain drops everything.
    src_ar_hs = 1'b1;
    tick();
    src_ar_hs = 1'b0;
    req_valid = 1'b1; req_mode = DDR_TO_HOST;
    tick();
    tick();
    chk("rdr_hold", 32'(hold_off), 32'd1);
    chk("rdr_mode", 32'(mode), 32'(HOST_TO_DDR));
    reset = 1'b1;
    #1;
    chk("rdr_mode_rst", 32'(mode), 32'(DDR_TO_HOST));
    chk("rdr_hold_rst", 32'(hold_off), 32'd0);
    chk("rdr_udf_rst", 32'(err_udf), 32'd0);
    chk("rdr_busy_rst", 32'(busy), 32'd0);
    req_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("rdr_hold_after", 32'(hold_off), 32'd0);
    chk("rdr_rdy_after", 32'(req_ready), 32'd0);

    // Saturation: 64 reads fit, the 65th overflows and is not counted.
    src_ar_hs = 1'b1;
    repeat (64) tick();
    chk("ovf_at_max", 32'(err_ovf), 32'd0);
    chk("ovf_busy", 32'(busy), 32'd1);
    tick();
    src_ar_hs = 1'b0;
    chk("ovf_set", 32'(err_ovf), 32'd1);
    src_r_last_hs = 1'b1;
    repeat (63) tick();
    chk("ovf_drain_busy", 32'(busy), 32'd1);
    tick();
    src_r_last_hs = 1'b0;
    chk("ovf_drain_done", 32'(busy), 32'd0);
    chk("ovf_no_udf", 32'(err_udf), 32'd0);
    chk("ovf_sticky", 32'(err_ovf), 32'd1);

    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
